// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants and types for the two-port RAM arbiter.
//               Holds the default RAM geometry, the port identifiers used
//               for grant indexing and read-ownership tagging, and the fixed
//               read-return latency.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int ADDRESS_DEF = 6;
  localparam int CNT_W_DEF   = 16;

  // Port identifiers double as bit positions in the req/gnt vectors.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Cycles from a read grant to the owning port's rvalid pulse.
  localparam int RD_LAT = 2;

  // One stage of the read-ownership pipe.
  typedef struct packed {
    logic valid;
    logic id;
  } pend_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. A lone requester is
//               granted at once; on a tie the port that was not granted
//               most recently wins. The last-grant pointer moves only when
//               a grant is issued and resets to port B, so A wins the first
//               tie.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               req   - request vector, bit PORT_A / bit PORT_B
//               gnt   - one-hot (or zero) grant vector, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_last;  // port that received the most recent grant

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last == PORT_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_B;
    end else if (|gnt) begin
      r_last <= gnt[PORT_B] ? PORT_B : PORT_A;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port synchronous RAM between requesters A
//               and B. At most one command per cycle is driven to the RAM,
//               chosen round-robin on contention. Read data returns to the
//               issuing port RD_LAT cycles after its grant. Saturating
//               per-port grant counters are kept for debug/performance.
// Ports       : clk, rst_n              - clock, async active-low reset
//               a_req/a_wnr/a_addr/a_data - port A command
//               a_gnt                   - port A command accepted (comb)
//               a_rvalid/a_rdata        - port A read return
//               b_*                     - same set for port B
//               ram_data/ram_addr/ram_wnr - RAM command (comb)
//               ram_q                   - RAM read data, valid cycle after read
//               clr_cnt                 - synchronous clear of both counters
//               a_cnt/b_cnt             - saturating grant counters
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADDRESS = ADDRESS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  // port A
  input  logic               a_req,
  input  logic               a_wnr,
  input  logic [ADDRESS-1:0] a_addr,
  input  logic [WIDTH-1:0]   a_data,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [WIDTH-1:0]   a_rdata,
  // port B
  input  logic               b_req,
  input  logic               b_wnr,
  input  logic [ADDRESS-1:0] b_addr,
  input  logic [WIDTH-1:0]   b_data,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [WIDTH-1:0]   b_rdata,
  // RAM side
  output logic [WIDTH-1:0]   ram_data,
  output logic [ADDRESS-1:0] ram_addr,
  output logic               ram_wnr,
  input  logic [WIDTH-1:0]   ram_q,
  // counters
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   a_cnt,
  output logic [CNT_W-1:0]   b_cnt
);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [1:0] w_req;
  logic [1:0] w_gnt;

  assign w_req = {b_req, a_req};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign a_gnt = w_gnt[PORT_A];
  assign b_gnt = w_gnt[PORT_B];

  // --------------------------------------------------------------------------
  // RAM command mux. With no grant the RAM sees a read of address 0, which
  // has no side effect and is never tagged as pending.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_wnr  = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (w_gnt[PORT_A]) begin
      ram_wnr  = a_wnr;
      ram_addr = a_addr;
      ram_data = a_data;
    end else if (w_gnt[PORT_B]) begin
      ram_wnr  = b_wnr;
      ram_addr = b_addr;
      ram_data = b_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read-ownership pipe. Stage 0 is live during the cycle ram_q is valid and
  // steers the capture into the owner's rdata; stage RD_LAT-1 is live during
  // the cycle that rdata is presented and drives rvalid.
  // --------------------------------------------------------------------------
  pend_t [RD_LAT-1:0] r_pend;
  pend_t              w_issue;

  always_comb begin
    w_issue.valid = (|w_gnt) && !ram_wnr;
    w_issue.id    = w_gnt[PORT_B] ? PORT_B : PORT_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= {r_pend[RD_LAT-2:0], w_issue};
    end
  end

  logic [WIDTH-1:0] r_a_rdata;
  logic [WIDTH-1:0] r_b_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (r_pend[RD_LAT-2].valid) begin
      if (r_pend[RD_LAT-2].id == PORT_A) begin
        r_a_rdata <= ram_q;
      end else begin
        r_b_rdata <= ram_q;
      end
    end
  end

  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign a_rvalid = r_pend[RD_LAT-1].valid && (r_pend[RD_LAT-1].id == PORT_A);
  assign b_rvalid = r_pend[RD_LAT-1].valid && (r_pend[RD_LAT-1].id == PORT_B);

  // --------------------------------------------------------------------------
  // Saturating grant counters; clear wins over increment.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr_cnt) begin
          r_cnt[i] <= '0;
        end else if (w_gnt[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign a_cnt = r_cnt[PORT_A];
  assign b_cnt = r_cnt[PORT_B];

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a
//               behavioural single-port synchronous RAM attached. Counters
//               are built 4 bits wide so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int WIDTH   = 8;
  localparam int ADDRESS = 6;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               a_req, a_wnr, b_req, b_wnr;
  logic [ADDRESS-1:0] a_addr, b_addr;
  logic [WIDTH-1:0]   a_data, b_data;
  logic               a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [WIDTH-1:0]   a_rdata, b_rdata;
  logic [WIDTH-1:0]   ram_data;
  logic [ADDRESS-1:0] ram_addr;
  logic               ram_wnr;
  logic [WIDTH-1:0]   ram_q;
  logic               clr_cnt;
  logic [CNT_W-1:0]   a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .WIDTH   (WIDTH),
    .ADDRESS (ADDRESS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_wnr    (a_wnr),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_wnr    (b_wnr),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_wnr  (ram_wnr),
    .ram_q    (ram_q),
    .clr_cnt  (clr_cnt),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
  );

  // Single-port synchronous RAM: write at the edge, or register the read.
  logic [WIDTH-1:0] mem [2**ADDRESS];
  always @(posedge clk) begin
    if (ram_wnr) mem[ram_addr] <= ram_data;
    else         ram_q <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0;
    a_req = 1'b0; a_wnr = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_wnr = 1'b0; b_addr = '0; b_data = '0;
    #12;
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata",  a_rdata,  0);
    chk("rst_b_rdata",  b_rdata,  0);
    chk("rst_a_cnt",    a_cnt,    0);
    chk("rst_b_cnt",    b_cnt,    0);
    chk("idle_ram_wnr", ram_wnr,  0);
    chk("idle_ram_addr", ram_addr, 0);
    tick; rst_n = 1'b1;

    // A writes 0x5A to 3, then reads it back
    tick; a_req = 1; a_wnr = 1; a_addr = 3; a_data = 8'h5A; #1;
    chk("wr_a_gnt", a_gnt, 1);
    chk("wr_b_gnt", b_gnt, 0);
    chk("wr_ram_wnr", ram_wnr, 1);
    chk("wr_ram_addr", ram_addr, 3);
    chk("wr_ram_data", ram_data, 8'h5A);
    tick; a_wnr = 0; #1;
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_ram_wnr", ram_wnr, 0);
    tick; a_req = 0; #1;
    chk("rd_n1_a_rvalid", a_rvalid, 0);
    chk("rd_n1_a_gnt", a_gnt, 0);
    tick; #1;
    chk("rd_n2_a_rvalid", a_rvalid, 1);
    chk("rd_n2_a_rdata", a_rdata, 8'h5A);
    chk("rd_n2_b_rvalid", b_rvalid, 0);
    tick; #1;
    chk("rd_n3_a_rvalid", a_rvalid, 0);
    chk("rd_n3_a_rdata_hold", a_rdata, 8'h5A);

    // preload mem[1]=0x11 via A, mem[2]=0x22 via B
    tick; a_req = 1; a_wnr = 1; a_addr = 1; a_data = 8'h11; #1;
    chk("pre_a_gnt", a_gnt, 1);
    tick; a_req = 0; b_req = 1; b_wnr = 1; b_addr = 2; b_data = 8'h22; #1;
    chk("pre_b_gnt", b_gnt, 1);

    // continuous contention: A wins first tie, then alternate
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) begin
        a_req = 1; a_wnr = 0; a_addr = 1;
        b_wnr = 0; b_addr = 2;
      end
      if (i == 6) begin
        a_req = 0; b_req = 0;
      end
      #1;
      if (i < 6) begin
        chk($sformatf("rr_a_gnt_%0d", i), a_gnt, (i % 2) == 0);
        chk($sformatf("rr_b_gnt_%0d", i), b_gnt, (i % 2) == 1);
      end
      if (i >= 2) begin
        chk($sformatf("rr_a_rvalid_%0d", i), a_rvalid, (i % 2) == 0);
        chk($sformatf("rr_b_rvalid_%0d", i), b_rvalid, (i % 2) == 1);
        if ((i % 2) == 0) chk($sformatf("rr_a_rdata_%0d", i), a_rdata, 8'h11);
        else              chk($sformatf("rr_b_rdata_%0d", i), b_rdata, 8'h22);
      end else begin
        chk($sformatf("rr_no_rvalid_%0d", i), {a_rvalid, b_rvalid}, 0);
      end
    end
    chk("rr_a_cnt", a_cnt, 6);
    chk("rr_b_cnt", b_cnt, 4);

    // read/write ordering on address 7
    tick; a_req = 1; a_wnr = 1; a_addr = 7; a_data = 8'h77; #1;
    chk("ord_pre_a_gnt", a_gnt, 1);
    tick; a_wnr = 0; #1;
    chk("ord_rd1_a_gnt", a_gnt, 1);
    tick; a_req = 0; b_req = 1; b_wnr = 1; b_addr = 7; b_data = 8'h99; #1;
    chk("ord_wr_b_gnt", b_gnt, 1);
    chk("ord_wr_ram_wnr", ram_wnr, 1);
    tick; b_req = 0; a_req = 1; a_wnr = 0; a_addr = 7; #1;
    chk("ord_rd2_a_gnt", a_gnt, 1);
    chk("ord_old_rvalid", a_rvalid, 1);
    chk("ord_old_rdata", a_rdata, 8'h77);
    tick; a_req = 0; #1;
    chk("ord_gap_rvalid", a_rvalid, 0);
    tick; #1;
    chk("ord_new_rvalid", a_rvalid, 1);
    chk("ord_new_rdata", a_rdata, 8'h99);
    chk("ord_a_cnt", a_cnt, 9);
    chk("ord_b_cnt", b_cnt, 5);

    // reset in the cycle after a read grant
    tick; a_req = 1; a_wnr = 0; a_addr = 3; #1;
    chk("mrst_a_gnt", a_gnt, 1);
    tick; a_req = 0; rst_n = 0; #1;
    chk("mrst_a_cnt", a_cnt, 0);
    chk("mrst_b_cnt", b_cnt, 0);
    chk("mrst_a_rdata", a_rdata, 0);
    tick; rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("mrst_no_rvalid_%0d", i), {a_rvalid, b_rvalid}, 0);
      chk($sformatf("mrst_rdata_%0d", i), a_rdata, 0);
    end
    tick; a_req = 1; a_wnr = 0; a_addr = 1; b_req = 1; b_wnr = 0; b_addr = 2; #1;
    chk("mrst_tie_a_gnt", a_gnt, 1);
    chk("mrst_tie_b_gnt", b_gnt, 0);
    tick; a_req = 0; b_req = 0; #1;
    chk("abandon_b_gnt", b_gnt, 0);
    tick; #1;
    chk("mrst_tie_a_rvalid", a_rvalid, 1);
    chk("mrst_tie_a_rdata", a_rdata, 8'h11);
    chk("abandon_b_rvalid", b_rvalid, 0);

    // B alone, five commands; then clear concurrent with a grant
    tick; clr_cnt = 1; #1;
    tick; clr_cnt = 0; #1;
    chk("clr_a_cnt", a_cnt, 0);
    chk("clr_b_cnt", b_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick; b_req = 1; b_wnr = 1; b_addr = 6'(10 + i); b_data = 8'(i); #1;
      chk($sformatf("bonly_b_gnt_%0d", i), b_gnt, 1);
    end
    tick; clr_cnt = 1; b_addr = 6'd20; #1;
    chk("bonly_b_cnt", b_cnt, 5);
    chk("bonly_a_cnt", a_cnt, 0);
    chk("clrgnt_b_gnt", b_gnt, 1);
    tick; clr_cnt = 0; b_req = 0; #1;
    chk("clrgnt_b_cnt", b_cnt, 0);

    // saturation of the 4-bit A counter
    for (int i = 0; i < 20; i++) begin
      tick; a_req = 1; a_wnr = 1; a_addr = 6'(40 + i); a_data = 8'(i); #1;
      if (i == 15) chk("sat_a_cnt_15", a_cnt, 4'hF);
    end
    tick; a_req = 0; #1;
    chk("sat_a_cnt_20", a_cnt, 4'hF);
    chk("sat_b_cnt", b_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM (registered read address, write-not-read control) between two requesters, A and B.
- Issues at most one RAM command per cycle and arbitrates round-robin on contention.
- Returns read data to the requester that issued the read, with a fixed latency.
- Sits between the client logic and the RAM; also keeps per-port saturating grant counters for debug and performance.

Parameters:
- WIDTH, 8, data width of the RAM word.
- ADDRESS, 6, address width; RAM depth is 2**ADDRESS.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A command request.
- a_wnr  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDRESS  port A address.
- a_data  in  WIDTH  port A write data.
- a_gnt  out  1  port A command accepted this cycle (combinational).
- a_rvalid  out  1  port A read data valid (one-cycle pulse).
- a_rdata  out  WIDTH  port A read data.
- b_req, b_wnr, b_addr, b_data, b_gnt, b_rvalid, b_rdata: same as the A ports, for port B.
- ram_data  out  WIDTH  RAM write data.
- ram_addr  out  ADDRESS  RAM address.
- ram_wnr  out  1  RAM write-not-read.
- ram_q  in  WIDTH  RAM read output; valid the cycle after a read is issued.
- clr_cnt  in  1  synchronous clear of both grant counters.
- a_cnt  out  CNT_W  number of commands granted to A.
- b_cnt  out  CNT_W  number of commands granted to B.

Behaviour:
- Handshake:
  - A requester holds req/wnr/addr/data stable until it sees gnt high in the same cycle.
  - gnt is high for exactly one cycle per accepted command.
  - req may drop without a grant; the command is then abandoned with no side effects.
- Arbitration:
  - Only one req high -> that port is granted.
  - Both high -> grant the port not granted most recently. The last-grant pointer resets to B, so A wins the first tie.
  - Pointer updates only on a grant. An idle cycle does not change it.
- RAM drive (combinational from the granted port):
  - ram_addr/ram_data/ram_wnr come from the granted port.
  - No grant -> ram_wnr=0, ram_addr=0, ram_data=0 (a harmless read).
- Read pipeline, fixed latency 2:
  - Read granted in cycle N -> ram_q is valid in cycle N+1.
  - ram_q is registered at the end of N+1 into the granted port's rdata.
  - That port's rvalid pulses in cycle N+2.
  - A two-stage pending pipe {valid, id} tracks ownership; it is fully pipelined, so one read can issue every cycle.
- rdata holds its last value when rvalid is low.
- Writes: no response. The write takes effect at the end of the granted cycle.
- Ordering:
  - A read captured in N+1 returns the value before any write granted in N+1, and after any write granted in N or earlier.
  - A read granted in the cycle directly after a write to the same address returns the new data.
- Counters:
  - a_cnt/b_cnt increment on the port's gnt and saturate at all-ones.
  - clr_cnt has priority over increment.
- Reset (async assert, sync-released state):
  - Outputs: a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, a_cnt = b_cnt = 0.
  - Internal state: pending pipe cleared, pointer = B.
- Reset asserted mid-read: in-flight reads are dropped and no rvalid is produced after release.
- No FSM beyond the pointer and the pending pipe. The block never stalls once a grant is given.

Decomposition:
- Shared package ram_arb_pkg holds:
  - Default WIDTH and ADDRESS.
  - Port-ID constants PORT_A = 1'b0 and PORT_B = 1'b1.
  - The read latency constant RD_LAT = 2.
- One natural sub-module, rr_arb2: a two-requester round-robin arbiter.
  - Inputs: req[1:0]. Outputs: gnt[1:0].
  - Owns the last-grant pointer, with the same clk/rst_n.
- The pending pipe, the data mux and the counters stay in ram_arbiter.

Test Plan:
- A writes 0x5A to addr 3, then A reads addr 3 -> a_gnt in both cycles; a_rvalid two cycles after the read grant with a_rdata=0x5A; b_rvalid stays 0.
- A and B request reads continuously (A: addr 1, B: addr 2; mem[1]=0x11, mem[2]=0x22) -> grants alternate A,B,A,B starting with A; rvalid pulses alternate with correct data at 1 per cycle.
- Read of addr 7 granted in cycle N while B writes 0x99 to addr 7 in N+1 -> read returns the old value. A read granted in N+2 returns 0x99.
- Reset asserted in the cycle after a read grant, then released -> no rvalid ever appears; counters = 0; first tie goes to A.
- Only B requests 5 commands -> b_gnt every cycle; b_cnt=5, a_cnt=0. Then clr_cnt concurrent with a grant -> b_cnt=0.
- Force a_cnt near saturation (CNT_W=4 build) with 20 grants -> a_cnt stays 0xF.
